trace_replayer: RTL

//  Sequential counterpart of the trace-ordering block: consumes a packed cell-order list
//  (25 x 5-bit cell indices, entry k at order[5k+4:5k]) plus a valid length, and replays
//  it one cell per step. Emits each cell index with a strobe and rebuilds the 25-bit
//  5x5 trace mask cell by cell, for wand-path animation and display in the spell game.

---
 rtl/trace_pkg.sv | 15 +
 rtl/trace_replayer_if.sv | 25 ++
 rtl/trace_replayer_step_timer.sv | 37 +++
 rtl/trace_replayer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared constants and FSM encoding for the trace ordering and replay blocks.
package trace_pkg;

    localparam int GRID_CELLS = 25;
    localparam int IDX_W      = 5;
    localparam int ORDER_W    = GRID_CELLS * IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        HOLD,
        FINISH
    } state_e;

endpackage

// File: rtl/trace_replayer_if.sv
// Request and replay-output bundle between the controller and trace_replayer.
interface trace_replayer_if;
    import trace_pkg::*;

    logic                  start;
    logic [ORDER_W-1:0]    order;
    logic [IDX_W-1:0]      length;
    logic                  busy;
    logic                  cell_valid;
    logic [IDX_W-1:0]      cell_idx;
    logic [GRID_CELLS-1:0] trace;
    logic                  done;
    logic                  error;

    modport master (
        output start, order, length,
        input  busy, cell_valid, cell_idx, trace, done, error
    );

    modport slave (
        input  start, order, length,
        output busy, cell_valid, cell_idx, trace, done, error
    );

endinterface

// File: rtl/trace_replayer_step_timer.sv
// Loadable down-counter; tick_o is high while the count sits at zero.
module step_timer #(
    parameter int STEP_CYCLES = 12_500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = $clog2(STEP_CYCLES);
    // Two cycles of the step are spent on the EMIT edge and the expiry edge.
    localparam logic [W-1:0] LOAD_VAL = W'(STEP_CYCLES - 2);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = LOAD_VAL;
        else if (en_i && count_q != '0)
            count_d = count_q - 1'b1;
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clock) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign tick_o = (count_q == '0);

endmodule

// File: rtl/trace_replayer.sv
// Replays a latched cell-order list one cell per step, rebuilding the trace mask.
module trace_replayer
    import trace_pkg::*;
#(
    parameter int STEP_CYCLES = 12_500_000
) (
    input  logic             clock,
    input  logic             reset,
    trace_replayer_if.slave  bus
);

    state_e                state_q, state_d;
    logic [ORDER_W-1:0]    order_q, order_d;
    logic [IDX_W-1:0]      len_q, len_d;
    logic [IDX_W-1:0]      k_q, k_d;
    logic                  busy_q, busy_d;
    logic                  cell_valid_q, cell_valid_d;
    logic [IDX_W-1:0]      cell_idx_q, cell_idx_d;
    logic [GRID_CELLS-1:0] trace_q, trace_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  timer_load, timer_tick;
    logic [IDX_W-1:0]      entry, len_clamped;

    assign entry       = order_q[IDX_W*int'(k_q) +: IDX_W];
    assign len_clamped = (bus.length > IDX_W'(GRID_CELLS)) ? IDX_W'(GRID_CELLS) : bus.length;

    step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
        .clock  (clock),
        .reset  (reset),
        .load_i (timer_load),
        .en_i   (state_q == HOLD),
        .tick_o (timer_tick)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        order_d      = order_q;
        len_d        = len_q;
        k_d          = k_q;
        busy_d       = busy_q;
        cell_valid_d = 1'b0;
        cell_idx_d   = cell_idx_q;
        trace_d      = trace_q;
        done_d       = 1'b0;
        error_d      = error_q;
        timer_load   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    order_d = bus.order;
                    len_d   = len_clamped;
                    trace_d = '0;
                    error_d = 1'b0;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = (len_clamped == '0) ? FINISH : EMIT;
                end
            end
            EMIT: begin
                cell_valid_d = 1'b1;
                cell_idx_d   = entry;
                if (entry < IDX_W'(GRID_CELLS))
                    trace_d = trace_q | (GRID_CELLS'(1) << entry);
                else
                    error_d = 1'b1;
                timer_load = 1'b1;
                state_d    = HOLD;
            end
            HOLD: begin
                if (timer_tick) begin
                    if (k_q == len_q - 1'b1) begin
                        state_d = FINISH;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = EMIT;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            k_q          <= '0;
            busy_q       <= 1'b0;
            cell_valid_q <= 1'b0;
            cell_idx_q   <= '0;
            trace_q      <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            k_q          <= k_d;
            busy_q       <= busy_d;
            cell_valid_q <= cell_valid_d;
            cell_idx_q   <= cell_idx_d;
            trace_q      <= trace_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // NOTE: the order copy is pure datapath, always written on start before
    // it is read, so it carries no reset.
    always_ff @(posedge clock) begin
        order_q <= order_d;
    end

    assign bus.busy       = busy_q;
    assign bus.cell_valid = cell_valid_q;
    assign bus.cell_idx   = cell_idx_q;
    assign bus.trace      = trace_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule
